// File: rtl/rast_span_emitter.sv
// rast_span_emitter: buffers horizontal span commands in a small FIFO and
// expands each span into single-pixel writes toward the DVI framebuffer.
// A one-cycle rast_done pulse follows the last pixel (or the empty span)
// marked last-of-frame.
// Optional feature: define RAST_SPAN_EMITTER_CLIP_EN to clip spans to
// H_RES x V_RES when they are popped; otherwise coordinates pass through.
module rast_span_emitter #(
    parameter int FIFO_DEPTH = 4,
    parameter int H_RES      = 640,
    parameter int V_RES      = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [9:0] cmd_x0,
    input  logic [9:0] cmd_x1,
    input  logic [8:0] cmd_y,
    input  logic [2:0] cmd_color,
    input  logic       cmd_last,
    output logic       rast_pixel_rdy,
    output logic [2:0] rast_color_input,
    output logic [9:0] rast_width,
    output logic [8:0] rast_height,
    output logic       rast_done,
    input  logic       read_rast_pixel_rdy,
    output logic       busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
        H_RES < 1 || H_RES > 1024 || V_RES < 1 || V_RES > 512) begin : g_bad_param
        $error("rast_span_emitter: illegal parameter value");
    end

    // FIFO storage and bookkeeping
    logic [32:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          cmd_ready_q, cmd_ready_d;
    logic          push_s, pop_s;

    // Span being emitted
    state_t        state_q, state_d;
    logic [9:0]    cur_x_q, cur_x_d;
    logic [9:0]    end_x_q, end_x_d;
    logic [8:0]    y_q, y_d;
    logic [2:0]    color_q, color_d;
    logic          last_q, last_d;

    // Registered status outputs
    logic          pix_rdy_q, pix_rdy_d;
    logic          done_q, done_d;
    logic          busy_q, busy_d;

    // Head-of-FIFO fields and their (optionally clipped) load values
    logic [32:0]   head_s;
    logic [9:0]    head_x0_s, head_x1_s;
    logic [8:0]    head_y_s;
    logic [2:0]    head_color_s;
    logic          head_last_s;
    logic [9:0]    ld_x1_s;
    logic          ld_empty_s;

    assign push_s       = cmd_valid && cmd_ready_q;
    assign head_s       = mem_q[rd_ptr_q];
    assign head_x0_s    = head_s[32:23];
    assign head_x1_s    = head_s[22:13];
    assign head_y_s     = head_s[12:4];
    assign head_color_s = head_s[3:1];
    assign head_last_s  = head_s[0];

`ifdef RAST_SPAN_EMITTER_CLIP_EN
    localparam logic [9:0] X_MAX = 10'(H_RES - 1);
    localparam logic [8:0] Y_MAX = 9'(V_RES - 1);

    // Clamp the span end to the screen and flag spans that fall off it
    always_comb begin
        if (head_x1_s > X_MAX) begin
            ld_x1_s = X_MAX;
        end else begin
            ld_x1_s = head_x1_s;
        end
        ld_empty_s = (head_y_s > Y_MAX) || (head_x0_s > X_MAX) || (head_x0_s > ld_x1_s);
    end
`else
    // Coordinates are trusted as-is; only x0 > x1 makes a span empty
    always_comb begin
        ld_x1_s    = head_x1_s;
        ld_empty_s = (head_x0_s > head_x1_s);
    end
`endif

    // Span FIFO storage; data needs no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {cmd_x0, cmd_x1, cmd_y, cmd_color, cmd_last};
        end
    end

    // FIFO pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State register plus span and FIFO registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cur_x_q     <= 10'd0;
            end_x_q     <= 10'd0;
            y_q         <= 9'd0;
            color_q     <= 3'd0;
            last_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            cmd_ready_q <= 1'b0;
            pix_rdy_q   <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_x_q     <= cur_x_d;
            end_x_q     <= end_x_d;
            y_q         <= y_d;
            color_q     <= color_d;
            last_q      <= last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            cmd_ready_q <= cmd_ready_d;
            pix_rdy_q   <= pix_rdy_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: pop and load a span in IDLE, walk x in EMIT
    always_comb begin
        state_d = state_q;
        pop_s   = 1'b0;
        cur_x_d = cur_x_q;
        end_x_d = end_x_q;
        y_d     = y_q;
        color_d = color_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop_s   = 1'b1;
                    cur_x_d = head_x0_s;
                    end_x_d = ld_x1_s;
                    y_d     = head_y_s;
                    color_d = head_color_s;
                    last_d  = head_last_s;
                    if (!ld_empty_s) begin
                        state_d = ST_EMIT;
                    end else if (head_last_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (read_rast_pixel_rdy) begin
                    if (cur_x_q == end_x_q) begin
                        state_d = last_q ? ST_DONE : ST_IDLE;
                    end else begin
                        cur_x_d = cur_x_q + 10'd1;
                        state_d = ST_EMIT;
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        pix_rdy_d   = (state_d == ST_EMIT);
        done_d      = (state_d == ST_DONE);
        busy_d      = (count_d != '0) || (state_d != ST_IDLE);
        cmd_ready_d = (count_d != FULL_CNT);
    end

    assign cmd_ready        = cmd_ready_q;
    assign rast_pixel_rdy   = pix_rdy_q;
    assign rast_done        = done_q;
    assign busy             = busy_q;
    assign rast_width       = cur_x_q;
    assign rast_height      = y_q;
    assign rast_color_input = color_q;

endmodule

// File: tb/tb_rast_span_emitter.sv
// Directed bench for rast_span_emitter: a queue of expected pixels is filled
// when each span is accepted and drained as the framebuffer side consumes.
module tb_rast_span_emitter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [9:0] cmd_x0;
    logic [9:0] cmd_x1;
    logic [8:0] cmd_y;
    logic [2:0] cmd_color;
    logic       cmd_last;
    logic       rast_pixel_rdy;
    logic [2:0] rast_color_input;
    logic [9:0] rast_width;
    logic [8:0] rast_height;
    logic       rast_done;
    logic       read_rast_pixel_rdy;
    logic       busy;

    typedef struct packed {
        logic [9:0] x;
        logic [8:0] y;
        logic [2:0] c;
    } px_t;

    px_t exp_q[$];
    int  n_cmp     = 0;
    int  n_err     = 0;
    int  exp_done  = 0;
    int  done_seen = 0;
    int  done_cyc  = 0;
    int  cyc       = 0;
    int  t0        = 0;

    rast_span_emitter #(.FIFO_DEPTH(4), .H_RES(640), .V_RES(480)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_x0              (cmd_x0),
        .cmd_x1              (cmd_x1),
        .cmd_y               (cmd_y),
        .cmd_color           (cmd_color),
        .cmd_last            (cmd_last),
        .rast_pixel_rdy      (rast_pixel_rdy),
        .rast_color_input    (rast_color_input),
        .rast_width          (rast_width),
        .rast_height         (rast_height),
        .rast_done           (rast_done),
        .read_rast_pixel_rdy (read_rast_pixel_rdy),
        .busy                (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Scoreboard: every presented pixel must match the queue head; pop on consume
    always @(negedge clk) begin
        if (!rst) begin
            if (rast_pixel_rdy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pixel", 32'd1, 32'd0);
                end else begin
                    check("px_x", 32'(rast_width), 32'(exp_q[0].x));
                    check("px_y", 32'(rast_height), 32'(exp_q[0].y));
                    check("px_color", 32'(rast_color_input), 32'(exp_q[0].c));
                    if (read_rast_pixel_rdy) void'(exp_q.pop_front());
                end
            end
            if (rast_done) begin
                done_seen++;
                done_cyc = cyc;
            end
        end
    end

    // Drive one span, wait (bounded) for acceptance, then record expected pixels
    task automatic push_span(input logic [9:0] x0, input logic [9:0] x1, input logic [8:0] y,
                             input logic [2:0] c, input logic last);
        logic acc;
        int   n;
        int   lo;
        int   hi;
        bit   empty;
        px_t  p;
        cmd_x0 = x0; cmd_x1 = x1; cmd_y = y; cmd_color = c; cmd_last = last;
        cmd_valid = 1'b1;
        n = 0;
        do begin
            acc = cmd_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 200);
        check("accept", 32'(acc), 32'd1);
        lo = int'(x0);
        hi = int'(x1);
        empty = 1'b0;
`ifdef RAST_SPAN_EMITTER_CLIP_EN
        if (y >= 9'd480 || x0 >= 10'd640) empty = 1'b1;
        if (hi > 639) hi = 639;
`endif
        if (lo > hi) empty = 1'b1;
        if (!empty) begin
            for (int x = lo; x <= hi; x++) begin
                p.x = 10'(x); p.y = y; p.c = c;
                exp_q.push_back(p);
            end
        end
        if (last) exp_done++;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        while (done_seen != exp_done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_count", 32'(done_seen), 32'(exp_done));
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; read_rast_pixel_rdy = 1'b0;
        cmd_x0 = 10'd0; cmd_x1 = 10'd0; cmd_y = 9'd0; cmd_color = 3'd0; cmd_last = 1'b0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_pix_rdy", 32'(rast_pixel_rdy), 32'd0);
        check("rst_done", 32'(rast_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", 32'(cmd_ready), 32'd1);

        // Basic span with exact timing: pixels on samples 2..5, done on 6
        read_rast_pixel_rdy = 1'b1;
        push_span(10'd10, 10'd13, 9'd5, 3'b101, 1'b1);
        cmd_valid = 1'b0;
        check("basic_k1_rdy", 32'(rast_pixel_rdy), 32'd0);
        for (int k = 2; k <= 7; k++) begin
            @(posedge clk); #1;
            check("basic_rdy", 32'(rast_pixel_rdy), 32'((k >= 2) && (k <= 5)));
            check("basic_done", 32'(rast_done), 32'(k == 6));
        end
        check("basic_busy", 32'(busy), 32'd0);
        wait_done(5);

        // Empty last span: no pixels, done on the second sample
        push_span(10'd20, 10'd19, 9'd3, 3'd1, 1'b1);
        cmd_valid = 1'b0;
        check("elast_k1_done", 32'(rast_done), 32'd0);
        @(posedge clk); #1;
        check("elast_k2_done", 32'(rast_done), 32'd1);
        check("elast_k2_rdy", 32'(rast_pixel_rdy), 32'd0);
        @(posedge clk); #1;
        check("elast_k3_done", 32'(rast_done), 32'd0);
        check("elast_busy", 32'(busy), 32'd0);
        wait_done(5);

        // Empty non-last span: nothing at all
        push_span(10'd5, 10'd4, 9'd2, 3'd2, 1'b0);
        cmd_valid = 1'b0;
        check("enl_k1_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("enl_k2_done", 32'(rast_done), 32'd0);
        check("enl_k2_busy", 32'(busy), 32'd0);

        // Boundary span on the last row and columns
        push_span(10'd636, 10'd639, 9'd479, 3'd7, 1'b1);
        cmd_valid = 1'b0;
        wait_done(20);

        // Backpressure: consume every third cycle
        read_rast_pixel_rdy = 1'b0;
        push_span(10'd10, 10'd13, 9'd5, 3'b101, 1'b1);
        cmd_valid = 1'b0;
        for (int n = 0; n < 100 && done_seen != exp_done; n++) begin
            read_rast_pixel_rdy = (n % 3 == 2);
            @(posedge clk); #1;
        end
        read_rast_pixel_rdy = 1'b0;
        wait_done(5);

        // FIFO full: five accepts (first one popped into EMIT), sixth held off
        for (int i = 0; i < 5; i++) begin
            push_span(10'(10 * i), 10'(10 * i + 1), 9'(i), 3'(i), 1'b0);
        end
        check("full_ready", 32'(cmd_ready), 32'd0);
        cmd_x0 = 10'd60; cmd_x1 = 10'd61; cmd_y = 9'd6; cmd_color = 3'd6; cmd_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("full_held", 32'(cmd_ready), 32'd0);
        end
        read_rast_pixel_rdy = 1'b1;
        t0 = cyc;
        push_span(10'd60, 10'd61, 9'd6, 3'd6, 1'b1);
        cmd_valid = 1'b0;
        wait_done(100);
        check("full_drain_cycles", 32'(done_cyc - t0), 32'd17);

`ifdef RAST_SPAN_EMITTER_CLIP_EN
        // Clipping: right edge clamp and off-screen row
        push_span(10'd636, 10'd700, 9'd100, 3'd4, 1'b1);
        cmd_valid = 1'b0;
        wait_done(30);
        push_span(10'd10, 10'd20, 9'd480, 3'd4, 1'b1);
        cmd_valid = 1'b0;
        wait_done(10);
`endif

        // Reset in the middle of a 10-pixel span
        push_span(10'd100, 10'd109, 9'd7, 3'd2, 1'b1);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_third_px", 32'(rast_width), 32'd102);
        rst = 1'b1;
        #1;
        check("mid_rst_rdy", 32'(rast_pixel_rdy), 32'd0);
        check("mid_rst_done", 32'(rast_done), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd0);
        check("mid_rst_x", 32'(rast_width), 32'd0);
        check("mid_rst_y", 32'(rast_height), 32'd0);
        check("mid_rst_c", 32'(rast_color_input), 32'd0);
        exp_q.delete();
        exp_done--;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("mid_no_done", 32'(done_seen), 32'(exp_done));
            check("mid_no_rdy", 32'(rast_pixel_rdy), 32'd0);
        end
        push_span(10'd200, 10'd202, 9'd8, 3'd3, 1'b1);
        cmd_valid = 1'b0;
        wait_done(20);
        check("final_busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
